// File: rtl/byte_link_bus_bridge.sv
// Pin-side bridge: gathers a 4-beat little-endian address/wdata frame, performs one 32-bit
// req/ack memory access, then returns 4 read bytes in fixed DATA slots.
module byte_link_bus_bridge #(
  parameter int          WAIT_BEATS   = 2,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        link_start,
  input  logic        link_rw,
  input  logic [7:0]  link_addr_byte,
  input  logic [7:0]  link_wdata_byte,
  output logic [7:0]  link_rdata_byte,
  output logic        link_rdata_oe,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        frame_done,
  input  logic        err_clr,
  output logic        timeout_err,
  output logic        sync_err
);

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DATA} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        rw;
  logic [23:0] addr_lo, wdata_lo;
  logic [31:0] rbuf;
  logic        abort, last_beat, access_end, timeout_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign access_end = (cnt == 3'(WAIT_BEATS - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort     = 1'b0;
    last_beat = 1'b0;
    case (state)
      IDLE: begin
        if (link_start) begin
          state_nxt = ADDR;
          cnt_nxt   = 3'd0;
        end
      end
      ADDR: begin
        if (link_start) begin
          abort = 1'b1;
        end else if (cnt == 3'd3) begin
          state_nxt = ACCESS;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      ACCESS: begin
        if (link_start) begin
          abort = 1'b1;
        end else if (access_end) begin
          state_nxt = DATA;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: begin
        // A start on the final DATA beat is a clean back-to-back frame, not a resync.
        if (cnt == 3'd3) begin
          last_beat = 1'b1;
          state_nxt = link_start ? ADDR : IDLE;
          cnt_nxt   = 3'd0;
        end else if (link_start) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
    endcase
    if (abort) begin
      state_nxt = ADDR;
      cnt_nxt   = 3'd0;
    end
  end

  assign timeout_set = (state == ACCESS) && !link_start && mem_req && !mem_ack && access_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw          <= 1'b0;
      addr_lo     <= 24'd0;
      wdata_lo    <= 24'd0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      rbuf        <= 32'd0;
      timeout_err <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (link_start) begin
        rw <= link_rw;
      end
      if (link_start) begin
        mem_req <= 1'b0;
      end else if (state == ADDR) begin
        case (cnt[1:0])
          2'd0: begin addr_lo[7:0]   <= link_addr_byte; wdata_lo[7:0]   <= link_wdata_byte; end
          2'd1: begin addr_lo[15:8]  <= link_addr_byte; wdata_lo[15:8]  <= link_wdata_byte; end
          2'd2: begin addr_lo[23:16] <= link_addr_byte; wdata_lo[23:16] <= link_wdata_byte; end
          default: begin
            mem_addr  <= {link_addr_byte, addr_lo};
            mem_wdata <= {link_wdata_byte, wdata_lo};
            mem_we    <= rw;
            mem_req   <= 1'b1;
          end
        endcase
      end else if (state == ACCESS && mem_req) begin
        if (mem_ack) begin
          mem_req <= 1'b0;
          if (!rw) rbuf <= mem_rdata;
        end else if (access_end) begin
          mem_req <= 1'b0;
          if (!rw) rbuf <= TIMEOUT_DATA;
        end
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      timeout_err <= (timeout_err & ~err_clr) | timeout_set;
      sync_err    <= (sync_err & ~err_clr) | abort;
    end
  end

  assign frame_done      = last_beat;
  assign link_rdata_oe   = (state == DATA) && !rw;
  assign link_rdata_byte = link_rdata_oe ? rbuf[{cnt[1:0], 3'b000} +: 8] : 8'd0;

endmodule

// File: tb/tb_byte_link_bus_bridge.sv
// Scoreboard bench for byte_link_bus_bridge: expected read bytes are queued per frame and
// popped against the DATA-phase lane.
module tb_byte_link_bus_bridge;

  localparam int          WAIT = 2;
  localparam logic [31:0] TOD  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        link_start, link_rw;
  logic [7:0]  link_addr_byte, link_wdata_byte, link_rdata_byte;
  logic        link_rdata_oe, mem_req, mem_we, mem_ack, frame_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        err_clr, timeout_err, sync_err;

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_q[$];

  byte_link_bus_bridge #(.WAIT_BEATS(WAIT), .TIMEOUT_DATA(TOD)) dut (
    .clk(clk), .rst_n(rst_n), .link_start(link_start), .link_rw(link_rw),
    .link_addr_byte(link_addr_byte), .link_wdata_byte(link_wdata_byte),
    .link_rdata_byte(link_rdata_byte), .link_rdata_oe(link_rdata_oe),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .frame_done(frame_done),
    .err_clr(err_clr), .timeout_err(timeout_err), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic rwv);
    link_start = 1'b1;
    link_rw    = rwv;
    tick();
    link_start = 1'b0;
  endtask

  // Runs ADDR/ACCESS/DATA of a frame whose start pulse was already issued.
  // ackc < 0 means memory never acks; chain issues the next start on DATA beat 3.
  task automatic do_frame(input string nm, input logic rwv, input logic [31:0] a,
                          input logic [31:0] wd, input int ackc, input logic [31:0] rd,
                          input logic chain, input logic chain_rw);
    int req_cycles;
    logic [7:0] e;
    for (int k = 0; k < 4; k++) begin
      if (rwv) exp_q.push_back(8'h00);
      else if (ackc >= 0) exp_q.push_back(rd[8*k +: 8]);
      else exp_q.push_back(TOD[8*k +: 8]);
    end
    for (int k = 0; k < 4; k++) begin
      link_addr_byte  = a[8*k +: 8];
      link_wdata_byte = wd[8*k +: 8];
      tick();
    end
    link_addr_byte  = 8'h00;
    link_wdata_byte = 8'h00;
    checks++;
    if (mem_addr !== a) begin
      fails++; $display("FAIL %s mem_addr got %h want %h", nm, mem_addr, a);
    end
    checks++;
    if (mem_we !== rwv) begin
      fails++; $display("FAIL %s mem_we got %b want %b", nm, mem_we, rwv);
    end
    if (rwv) begin
      checks++;
      if (mem_wdata !== wd) begin
        fails++; $display("FAIL %s mem_wdata got %h want %h", nm, mem_wdata, wd);
      end
    end
    req_cycles = 0;
    for (int i = 0; i < WAIT; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      if (i == ackc) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
    end
    checks++;
    if (req_cycles != ((ackc >= 0) ? ackc + 1 : WAIT)) begin
      fails++; $display("FAIL %s mem_req_cycles got %0d want %0d", nm, req_cycles,
                        (ackc >= 0) ? ackc + 1 : WAIT);
    end
    for (int k = 0; k < 4; k++) begin
      // A stray ack after the window must not disturb the read buffer.
      if (k == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_A5A5;
      end
      checks++;
      if (mem_req !== 1'b0) begin
        fails++; $display("FAIL %s mem_req_in_data beat %0d got %b want 0", nm, k, mem_req);
      end
      checks++;
      if (exp_q.size() == 0) begin
        fails++; $display("FAIL %s scoreboard_empty beat %0d", nm, k);
      end else begin
        e = exp_q.pop_front();
        if (link_rdata_byte !== e) begin
          fails++; $display("FAIL %s rdata beat %0d got %h want %h", nm, k, link_rdata_byte, e);
        end
      end
      checks++;
      if (link_rdata_oe !== !rwv) begin
        fails++; $display("FAIL %s oe beat %0d got %b want %b", nm, k, link_rdata_oe, !rwv);
      end
      checks++;
      if (frame_done !== (k == 3)) begin
        fails++; $display("FAIL %s frame_done beat %0d got %b want %b", nm, k, frame_done, k == 3);
      end
      if (k == 3 && chain) begin
        link_start = 1'b1;
        link_rw    = chain_rw;
      end
      tick();
      mem_ack    = 1'b0;
      link_start = 1'b0;
    end
    if (!chain) begin
      checks++;
      if (link_rdata_oe !== 1'b0 || link_rdata_byte !== 8'h00 || frame_done !== 1'b0) begin
        fails++; $display("FAIL %s idle_outputs got oe=%b byte=%h done=%b want 0", nm,
                          link_rdata_oe, link_rdata_byte, frame_done);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_req, mem_we, link_rdata_oe, frame_done, timeout_err, sync_err} !== 6'd0 ||
        mem_addr !== 32'd0 || mem_wdata !== 32'd0 || link_rdata_byte !== 8'd0) begin
      fails++; $display("FAIL reset_state got req=%b we=%b oe=%b addr=%h wdata=%h want all 0",
                        mem_req, mem_we, link_rdata_oe, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_read();
    drive_start(1'b0);
    do_frame("read", 1'b0, 32'h1234_5678, 32'h0, 1, 32'hCAFE_F00D, 1'b0, 1'b0);
  endtask

  task automatic test_write();
    drive_start(1'b1);
    do_frame("write", 1'b1, 32'h0000_0010, 32'h1122_3344, 0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (timeout_err !== 1'b0 || sync_err !== 1'b0) begin
      fails++; $display("FAIL write_flags got to=%b sync=%b want 0 0", timeout_err, sync_err);
    end
  endtask

  task automatic test_timeout();
    drive_start(1'b0);
    do_frame("timeout", 1'b0, 32'h0000_0400, 32'h0, -1, 32'h0, 1'b0, 1'b0);
    checks++;
    if (timeout_err !== 1'b1) begin
      fails++; $display("FAIL timeout_set got %b want 1", timeout_err);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (timeout_err !== 1'b0) begin
      fails++; $display("FAIL timeout_clear got %b want 0", timeout_err);
    end
  endtask

  task automatic test_resync();
    drive_start(1'b0);
    for (int k = 0; k < 3; k++) begin
      link_addr_byte = 8'hAA;
      if (k == 2) begin
        link_start = 1'b1;
        link_rw    = 1'b1;
      end
      checks++;
      if (frame_done !== 1'b0) begin
        fails++; $display("FAIL resync_no_done beat %0d got %b want 0", k, frame_done);
      end
      tick();
      link_start = 1'b0;
    end
    checks++;
    if (sync_err !== 1'b1) begin
      fails++; $display("FAIL resync_sync_err got %b want 1", sync_err);
    end
    do_frame("resync", 1'b1, 32'h0000_0020, 32'h5566_7788, 0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    drive_start(1'b0);
    for (int k = 0; k < 4; k++) begin
      link_addr_byte = 8'h11 * 8'(k + 1);
      tick();
    end
    checks++;
    if (mem_req !== 1'b1) begin
      fails++; $display("FAIL rst_mid_req_before got %b want 1", mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'd0 || sync_err !== 1'b0 ||
        timeout_err !== 1'b0 || link_rdata_oe !== 1'b0) begin
      fails++; $display("FAIL rst_mid_async got req=%b addr=%h sync=%b to=%b oe=%b want 0",
                        mem_req, mem_addr, sync_err, timeout_err, link_rdata_oe);
    end
    #2;
    rst_n = 1'b1;
    tick();
    drive_start(1'b0);
    do_frame("post_reset", 1'b0, 32'h8765_4321, 32'h0, 0, 32'h0BAD_C0DE, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_start(1'b0);
    do_frame("b2b_first", 1'b0, 32'h0000_1000, 32'h0, 1, 32'h0102_0304, 1'b1, 1'b1);
    checks++;
    if (sync_err !== 1'b0) begin
      fails++; $display("FAIL b2b_no_sync_err got %b want 0", sync_err);
    end
    do_frame("b2b_second", 1'b1, 32'h0000_2000, 32'hA1B2_C3D4, 0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (sync_err !== 1'b0 || timeout_err !== 1'b0) begin
      fails++; $display("FAIL b2b_flags got sync=%b to=%b want 0 0", sync_err, timeout_err);
    end
  endtask

  initial begin
    rst_n = 1'b0; link_start = 1'b0; link_rw = 1'b0;
    link_addr_byte = 8'h00; link_wdata_byte = 8'h00;
    mem_rdata = 32'h0; mem_ack = 1'b0; err_clr = 1'b0;
    tick(); tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_read();
    test_write();
    test_timeout();
    test_resync();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
